// File: rtl/acc_frame_ctrl_if.sv
// Valid/ready stream carrying one packed complex word {re[15:0], im[15:0]}.
// The producer side uses the master modport and the consumer side uses the slave modport.
interface acc_frame_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/acc_frame_ctrl.sv
// acc_frame_ctrl: sequences one shared complex accumulation unit through frames.
// It clears the unit, feeds it FRAME_LEN samples, captures the frame sum and
// hands it out. It then clears the unit again.
// Optional macro ACC_PRESCALE_EN: each component of an accepted sample is
// arithmetically right-shifted by PRE_SHIFT before the zero check and the feed.
module acc_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = $clog2(FRAME_LEN),
  parameter int PRE_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    flush,
  acc_frame_ctrl_if.slave         s_if,
  acc_frame_ctrl_if.master        m_if,
  output logic [31:0]             acc_val_a,
  output logic                    acc_ce,
  output logic                    acc_nrst,
  input  logic [31:0]             acc_val_out
);

  // Reject parameter sets the counter and the shifter cannot represent.
  if (FRAME_LEN < 2 || FRAME_LEN > 65536 || PRE_SHIFT < 0 || PRE_SHIFT > 15) begin : g_bad_cfg
    $error("acc_frame_ctrl: illegal FRAME_LEN or PRE_SHIFT");
  end

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_ACCUM,
    ST_WAIT,
    ST_CAP,
    ST_OUT
  } state_t;

  // A zero word clears the unit, so any idle cycle presents this value instead.
  localparam logic [31:0]      GUARD = 32'h0000_0001;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [31:0]      m_data_q, m_data_d;
  logic [31:0]      acc_val_a_q, acc_val_a_d;
  logic             acc_ce_q, acc_ce_d;
  logic             acc_nrst_q, acc_nrst_d;

  logic             accept;
  logic [31:0]      x;

  assign s_if.ready = (state_q == ST_ACCUM);
  assign accept     = s_if.valid & s_if.ready;

  assign m_if.valid = m_valid_q;
  assign m_if.data  = m_data_q;
  assign acc_val_a  = acc_val_a_q;
  assign acc_ce     = acc_ce_q;
  assign acc_nrst   = acc_nrst_q;

  // The sample word as the unit should see it, after the optional prescale.
`ifdef ACC_PRESCALE_EN
  always_comb begin
    logic signed [15:0] re_s;
    logic signed [15:0] im_s;
    re_s = s_if.data[31:16];
    im_s = s_if.data[15:0];
    x    = {re_s >>> PRE_SHIFT, im_s >>> PRE_SHIFT};
  end
`else
  assign x = s_if.data;
`endif

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default here, so no path leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    acc_val_a_d = GUARD;
    acc_ce_d    = 1'b0;
    acc_nrst_d  = acc_nrst_q;

    case (state_q)
      ST_CLEAR: begin
        acc_nrst_d = 1'b1;
        cnt_d      = '0;
        state_d    = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (flush) begin
          acc_nrst_d = 1'b0;
          state_d    = ST_CLEAR;
        end else if (accept) begin
          // A zero sample still counts, but it is not fed because a zero word would clear the unit.
          if (x != 32'h0) begin
            acc_val_a_d = x;
            acc_ce_d    = 1'b1;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          acc_nrst_d = 1'b0;
          state_d    = ST_CLEAR;
        end else begin
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        if (flush) begin
          acc_nrst_d = 1'b0;
          state_d    = ST_CLEAR;
        end else begin
          m_data_d  = acc_val_out;
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_if.ready) begin
          m_valid_d  = 1'b0;
          acc_nrst_d = 1'b0;
          state_d    = ST_CLEAR;
        end
      end
      default: begin
        acc_nrst_d = 1'b0;
        state_d    = ST_CLEAR;
      end
    endcase
  end

  // State and registered outputs, with a synchronous reset back to the CLEAR state.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so that every flop samples values from before the edge.
    if (!nrst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 32'h0;
      acc_val_a_q <= GUARD;
      acc_ce_q    <= 1'b0;
      acc_nrst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      acc_val_a_q <= acc_val_a_d;
      acc_ce_q    <= acc_ce_d;
      acc_nrst_q  <= acc_nrst_d;
    end
  end

endmodule

// File: doc/acc_frame_ctrl.md
Name: acc_frame_ctrl

Overview:
- Sequencer that drives one shared complex accumulation unit.
- The unit has 16-bit real and 16-bit imag packed as {re, im}, synchronous clear on nrst low or when val_a is all-zero, and accumulates on ce.
- This block accepts a stream of packed complex samples, feeds exactly FRAME_LEN of them into the unit, captures the frame sum, and presents it on an output handshake.
- It then clears the unit for the next frame. It sits between the FFT butterfly output stream and the bin-sum consumer.

Parameters:
- FRAME_LEN, 64: samples per frame; legal range 2..65536.
- CNT_W, $clog2(FRAME_LEN): width of the sample counter.
- PRE_SHIFT, 6: arithmetic right shift per component; used only with ACC_PRESCALE_EN.

Ports:
- clk  in  1  clock; all logic on posedge.
- nrst  in  1  synchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_data  in  32  input sample {re[15:0], im[15:0]}, two's complement.
- flush  in  1  abort the current frame.
- m_valid  out  1  frame sum valid.
- m_ready  in  1  consumer ready.
- m_data  out  32  frame sum {re, im}.
- acc_val_a  out  32  to accumulator val_a.
- acc_ce  out  1  to accumulator ce.
- acc_nrst  out  1  to accumulator nrst.
- acc_val_out  in  32  from accumulator val_out.

Behaviour:
- Reset (nrst=0 at an edge):
  - state=CLEAR, cnt=0, m_valid=0, m_data=0.
  - acc_ce=0, acc_val_a=32'h0000_0001 (guard), acc_nrst=0.
- All accumulator-facing outputs are registered.
- acc_val_a must never be 0 unless a clear is intended. Whenever no sample is being fed, it holds the guard value 32'h0000_0001 with acc_ce=0.
- s_ready=1 only in ACCUM. Accept occurs when s_valid & s_ready.
- CLEAR (1 cycle):
  - acc_nrst=0 during this cycle; the unit clears at its end edge.
  - Next state ACCUM; acc_nrst<=1, cnt<=0.
- ACCUM:
  - On accept, with x = sample after optional prescale:
    - If x!=0: acc_val_a<=x, acc_ce<=1.
    - If x==0: acc_val_a<=guard, acc_ce<=0. The sample is counted but not fed, because feeding a zero word would clear the unit.
  - On no accept: acc_ce<=0, acc_val_a<=guard.
  - cnt increments on each accept.
  - Accept with cnt==FRAME_LEN-1 -> WAIT.
- WAIT (1 cycle): registered last sample is applied; the unit updates at the end edge. Outputs return to acc_ce<=0 and guard. Next state CAP.
- CAP (1 cycle): m_data<=acc_val_out, m_valid<=1 -> OUT.
- OUT:
  - Hold m_data and m_valid stable until m_ready.
  - On m_valid & m_ready: m_valid<=0, acc_nrst<=0 -> CLEAR.
  - m_ready while m_valid=0 is ignored.
- Latency: last accept edge to m_valid=1 is 3 clock edges. Minimum frame period is FRAME_LEN+4 cycles with m_ready held high.
- Arithmetic: wrap-around is owned by the unit (16-bit modular result per component). This block does no saturation.
- flush:
  - Flush=1 in ACCUM, WAIT or CAP drops the frame. acc_ce<=0, guard, acc_nrst<=0 -> CLEAR, m_valid stays 0. An accept in the same cycle as flush is consumed and discarded.
  - Flush in OUT or CLEAR is ignored; the completed sum is still delivered.
- nrst mid-frame or mid-OUT: state and outputs return to reset values and any pending sum is lost. acc_nrst=0 at the following cycle clears the unit.

Optional Feature:
- Macro ACC_PRESCALE_EN.
- Defined: each accepted component is arithmetically right-shifted by PRE_SHIFT (sign-extended, truncating toward minus infinity) before the zero check and feed. The zero check applies to the shifted word, so samples that shift to zero are counted and skipped.
- Undefined: samples are fed unmodified and PRE_SHIFT is unused.

Test Plan:
- Reset, FRAME_LEN=4, feed 0x00010002, 0x00030004, 0xFFFF0001, 0x00020000 back-to-back, m_ready=1 -> m_valid exactly 3 edges after the 4th accept; m_data=0x00050007; s_ready=0 until after CLEAR.
- FRAME_LEN=4, samples 0x00050005, 0x00000000, 0x00000000, 0x00010001 -> zero samples counted with acc_ce=0 and acc_val_a=0x00000001 (never 0 during ACCUM/WAIT); m_data=0x00060006.
- Overflow: 4 x 0x40004000 -> m_data=0x00000000 (16-bit wrap); a second frame of 4 x 0x00010001 -> 0x00040004, proving the clear between frames.
- Backpressure: m_ready=0 for 10 cycles after m_valid -> m_data stable, s_ready=0, acc_nrst=1; m_ready=1 -> one-cycle acc_nrst=0, then s_ready=1.
- Flush after 2 accepts of 0x00010001, then a full frame of 4 x 0x00020002 -> only one m_valid pulse with m_data=0x00080008. Flush during OUT -> sum still delivered.
- ACC_PRESCALE_EN, PRE_SHIFT=2, FRAME_LEN=2: samples 0x0008FFF8 and 0x00030003 -> second sample shifts to 0, skipped, m_data=0x0002FFFE.
